// File: rtl/issue_scoreboard.sv
// Issue scheduler: per-register busy tracking, RAW/WAW/unit-ready stall, and a
// drain sequence that blocks issue until every in-flight write has retired.
module issue_scoreboard #(
  parameter int unsigned NREG  = 64,
  parameter int unsigned NUNIT = 8,
  parameter int unsigned CNT_W = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     dec_valid,
  input  logic [$clog2(NUNIT)-1:0] dec_unit,
  input  logic [$clog2(NREG)-1:0]  dec_rs1,
  input  logic [$clog2(NREG)-1:0]  dec_rs2,
  input  logic [$clog2(NREG)-1:0]  dec_rd,
  input  logic                     dec_rd_we,
  input  logic [NUNIT-1:0]         unit_ready,
  input  logic                     wb0_valid,
  input  logic [$clog2(NREG)-1:0]  wb0_rn,
  input  logic                     wb1_valid,
  input  logic [$clog2(NREG)-1:0]  wb1_rn,
  input  logic                     flush,
  input  logic                     drain_req,
  output logic                     allow_advance,
  output logic                     issue_valid,
  output logic [$clog2(NUNIT)-1:0] issue_unit,
  output logic                     drain_done,
  output logic [NREG-1:0]          busy_vec,
  output logic [CNT_W-1:0]         stall_cnt
);

  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_e;

  state_e           state_q, state_d;
  logic [NREG-1:0]  busy_q, busy_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [NREG-1:0]  wb_clr;
  logic [NREG-1:0]  eff_busy;
  logic             raw, waw, go;

  // Writebacks release their register in the same cycle they retire.
  always_comb begin
    wb_clr = '0;
    if (wb0_valid) wb_clr[wb0_rn] = 1'b1;
    if (wb1_valid) wb_clr[wb1_rn] = 1'b1;
    eff_busy = busy_q & ~wb_clr;
  end

  always_comb begin
    raw = ((dec_rs1 != '0) && eff_busy[dec_rs1]) ||
          ((dec_rs2 != '0) && eff_busy[dec_rs2]);
    waw = dec_rd_we && (dec_rd != '0) && eff_busy[dec_rd];
    go  = dec_valid && (state_q == RUN) && !flush && !raw && !waw &&
          unit_ready[dec_unit];
  end

  // Next state: a new producer's set overrides a same-cycle clear.
  always_comb begin
    state_d = state_q;
    busy_d  = eff_busy;
    stall_d = stall_q;
    if (go && dec_rd_we && (dec_rd != '0)) busy_d[dec_rd] = 1'b1;
    if (dec_valid && !go && (stall_q != '1)) stall_d = stall_q + CNT_W'(1);
    case (state_q)
      RUN:     if (drain_req) state_d = DRAIN;
      DRAIN:   if (eff_busy == '0) state_d = DONE;
      DONE:    state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      busy_q  <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      stall_q <= stall_d;
    end
  end

  assign allow_advance = go;
  assign issue_valid   = go;
  assign issue_unit    = dec_unit;
  assign drain_done    = (state_q == DONE);
  assign busy_vec      = busy_q;
  assign stall_cnt     = stall_q;

endmodule

// File: doc/issue_scoreboard.md
Name: issue_scoreboard

Overview:
- Issue scheduler between instruction decode and the execution units.
- Tracks one pending-write (busy) bit per architectural register, and stalls decode on RAW/WAW hazards or when the target unit is not ready.
- Drives allow_advance back to decode and presents issue_valid/issue_unit to the units.
- Provides a drain sequence, used before mode changes or exceptions, that blocks issue until all in-flight writes retire.

Parameters:
- NREG, 64, number of architectural registers (register names are log2(NREG) = 6 bits).
- NUNIT, 8, number of execution units (unit index is 3 bits).
- CNT_W, 32, width of the stall performance counter.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- dec_valid  input  1  decode presents a valid instruction this cycle.
- dec_unit  input  3  target unit of the decoded instruction.
- dec_rs1  input  6  first source register; 0 means unused.
- dec_rs2  input  6  second source register; 0 means unused.
- dec_rd  input  6  destination register.
- dec_rd_we  input  1  instruction writes dec_rd.
- unit_ready  input  NUNIT  per-unit ready to accept an instruction.
- wb0_valid, wb1_valid  input  1 each  writeback port retires a write.
- wb0_rn, wb1_rn  input  6 each  register retired on each writeback port.
- flush  input  1  suppress issue this cycle.
- drain_req  input  1  request a drain (level; sampled in RUN only).
- allow_advance  output  1  decode may consume the current instruction.
- issue_valid  output  1  instruction issued to unit issue_unit this cycle.
- issue_unit  output  3  equals dec_unit.
- drain_done  output  1  one-cycle pulse when the drain completes.
- busy_vec  output  NREG  registered busy bits, for debug.
- stall_cnt  output  CNT_W  saturating count of stalled cycles.

Behaviour:
- Reset (asynchronous):
  - busy_vec = 0, stall_cnt = 0.
  - FSM in RUN; drain_done = 0.
  - allow_advance and issue_valid evaluate to 0 because no dec_valid is assumed.
- Register 0 is never marked busy, and a source of 0 never causes a hazard.
- Effective busy (combinational): eff_busy = busy_vec with any bit named by an active wb0 or wb1 port cleared. A writeback therefore releases a dependent instruction in the same cycle.
- Hazard conditions:
  - raw = (rs1 != 0 and eff_busy[rs1]) or (rs2 != 0 and eff_busy[rs2]).
  - waw = dec_rd_we and dec_rd != 0 and eff_busy[rd].
- Issue condition: go = dec_valid and state == RUN and not flush and not raw and not waw and unit_ready[dec_unit].
- Outputs from go:
  - issue_valid = allow_advance = go. This path is combinational, with zero-cycle latency from decode.
  - issue_unit = dec_unit at all times.
- Busy update on each clock edge:
  - Bits named by active writebacks are cleared.
  - If go and dec_rd_we and dec_rd != 0, busy[dec_rd] is set; the new value is visible from cycle N+1.
  - If a set and a clear hit the same register in one cycle, the set wins (new producer).
  - A writeback to a register that is not busy is ignored.
  - wb0 and wb1 naming the same register is legal and clears it once.
- stall_cnt increments when dec_valid and not go, and saturates at all-ones.
- Flush:
  - Blocks issue only.
  - Busy bits are untouched, because in-flight operations still retire through the writeback ports.
- FSM:
  - RUN: normal issue. On drain_req, move to DRAIN; issue is already blocked in the next cycle.
  - DRAIN: no issue. When eff_busy == 0, move to DONE.
  - DONE: drain_done = 1 for exactly this cycle, then move to RUN. If drain_req is still high when RUN is re-entered, a new drain starts.
- Reset mid-drain returns the FSM to RUN with all busy bits cleared.

Test Plan:
- Independent stream: rs1=1, rs2=2, rd=3 with rd_we, unit 2 ready -> issue_valid=1 in the same cycle; busy_vec[3]=1 in the next cycle.
- RAW stall: busy[5]=1, dec_rs1=5 -> allow_advance=0 and stall_cnt increments each cycle. Assert wb0_valid with wb0_rn=5 -> issue in that same cycle, and busy[5] goes to 0 on the next edge.
- WAW with set/clear collision: busy[7]=1, wb1 retires 7 while the issued instruction also writes rd=7 -> issue occurs and busy[7] remains 1.
- Unit not ready, then flush: unit_ready[4]=0 with dec_unit=4 -> no issue. With the unit ready but flush=1 -> no issue and busy_vec unchanged.
- Drain: busy bits {3,9} set, pulse drain_req -> no issue while draining. Retire 3, then 9 -> drain_done pulses exactly one cycle after eff_busy==0, then issue resumes.
- Register 0 and reset: rd=0 with rd_we -> busy[0] stays 0. Assert rst_n=0 asynchronously mid-DRAIN -> busy_vec=0, stall_cnt=0, FSM in RUN.
